// File: rtl/prio_encoder_scan.sv
// Registered priority scanner: captures an N-bit request vector and emits the
// index of every set bit, one per ready/valid handshake, in priority order.
module prio_encoder_scan #(
  parameter int N          = 8,
  parameter int W          = 3,
  parameter int HIGH_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         zero
);

  if (N < 2 || (2 ** W) < N) begin : g_bad_params
    $error("prio_encoder_scan: need N >= 2 and 2**W >= N");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           done_q, done_d;
  logic           zero_q, zero_d;

  // Later matches overwrite earlier ones, so the scan direction picks the winner.
  function automatic logic [W-1:0] prio_enc(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (HIGH_FIRST != 0) begin
        if (v[i]) idx = W'(i);
      end else begin
        if (v[N-1-i]) idx = W'(N-1-i);
      end
    end
    return idx;
  endfunction

  function automatic logic is_single(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    zero_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (req == '0) begin
            done_d = 1'b1;
            zero_d = 1'b1;
          end else begin
            pending_d = req;
            state_d   = SCAN;
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~(N'(1) << idx_q);
          if (last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
    // Outputs are precomputed from next-state so they leave the flops directly.
    valid_d = (state_d == SCAN);
    idx_d   = prio_enc(pending_d);
    last_d  = is_single(pending_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign busy      = valid_q;
  assign done      = done_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_prio_encoder_scan.sv
// Bench for prio_encoder_scan: both priority orders driven in parallel and
// compared against a queue-based model of the pending request indices.
module tb_prio_encoder_scan;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] req = '0;
  logic         out_ready = 1'b0;

  logic         h_valid, h_last, h_busy, h_done, h_zero;
  logic [W-1:0] h_idx;
  logic         l_valid, l_last, l_busy, l_done, l_zero;
  logic [W-1:0] l_idx;

  int checks = 0;
  int errors = 0;

  // Model: remaining indices in service order for each priority direction.
  int hq[$];
  int lq[$];
  bit busy_m = 1'b0;
  bit done_m = 1'b0;
  bit zero_m = 1'b0;

  prio_encoder_scan #(.N(N), .W(W), .HIGH_FIRST(1)) dut_h (
    .clk(clk), .rst(rst), .load(load), .req(req), .out_ready(out_ready),
    .out_valid(h_valid), .out_idx(h_idx), .out_last(h_last),
    .busy(h_busy), .done(h_done), .zero(h_zero)
  );

  prio_encoder_scan #(.N(N), .W(W), .HIGH_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .load(load), .req(req), .out_ready(out_ready),
    .out_valid(l_valid), .out_idx(l_idx), .out_last(l_last),
    .busy(l_busy), .done(l_done), .zero(l_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("hi_valid", int'(h_valid), int'(busy_m));
    chk("hi_idx",   int'(h_idx),   (hq.size() > 0) ? hq[0] : 0);
    chk("hi_last",  int'(h_last),  int'(hq.size() == 1));
    chk("hi_busy",  int'(h_busy),  int'(busy_m));
    chk("hi_done",  int'(h_done),  int'(done_m));
    chk("hi_zero",  int'(h_zero),  int'(zero_m));
    chk("lo_valid", int'(l_valid), int'(busy_m));
    chk("lo_idx",   int'(l_idx),   (lq.size() > 0) ? lq[0] : 0);
    chk("lo_last",  int'(l_last),  int'(lq.size() == 1));
    chk("lo_busy",  int'(l_busy),  int'(busy_m));
    chk("lo_done",  int'(l_done),  int'(done_m));
    chk("lo_zero",  int'(l_zero),  int'(zero_m));
  endtask

  // Advance the model by one clock using the inputs currently driven, then
  // let the DUTs clock and compare on the falling edge.
  task automatic tick();
    bit nd;
    bit nz;
    nd = 1'b0;
    nz = 1'b0;
    if (busy_m) begin
      if (out_ready) begin
        hq.delete(0);
        lq.delete(0);
        if (hq.size() == 0) begin
          busy_m = 1'b0;
          nd     = 1'b1;
        end
      end
    end else if (load) begin
      if (req == '0) begin
        nd = 1'b1;
        nz = 1'b1;
      end else begin
        for (int i = N - 1; i >= 0; i--) if (req[i]) hq.push_back(i);
        for (int i = 0; i < N; i++)      if (req[i]) lq.push_back(i);
        busy_m = 1'b1;
      end
    end
    done_m = nd;
    zero_m = nz;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_load(input logic [N-1:0] r);
    load = 1'b1;
    req  = r;
    tick();
    load = 1'b0;
    req  = '0;
  endtask

  // Reset asserted between edges: outputs must clear before any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    hq.delete();
    lq.delete();
    busy_m = 1'b0;
    done_m = 1'b0;
    zero_m = 1'b0;
    check_outputs();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    #2 rst = 1'b0;
    @(negedge clk);
    check_outputs();

    // Mixed pattern, full throughput: 7,5,2,0 and 0,2,5,7 then done.
    out_ready = 1'b1;
    do_load(8'b1010_0101);
    repeat (5) tick();

    // Backpressure for three cycles.
    out_ready = 1'b0;
    do_load(8'b0001_1000);
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // Zero load pulses zero and done, stays idle.
    do_load('0);
    repeat (2) tick();

    // Load during a scan is ignored.
    do_load(8'h3C);
    load = 1'b1;
    req  = 8'h81;
    tick();
    load = 1'b0;
    req  = '0;
    repeat (4) tick();

    // Reset mid-batch, then a fresh single-bit batch.
    do_load(8'hF0);
    tick();
    async_reset();
    tick();
    do_load(8'h01);
    repeat (3) tick();

    // Load issued in the done cycle is accepted immediately.
    do_load(8'h06);
    tick();
    tick();
    do_load(8'h09);
    repeat (3) tick();

    // Index 0 and index N-1 alone, and all bits set.
    do_load(8'h80);
    repeat (2) tick();
    do_load(8'hFF);
    repeat (9) tick();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      load      = ($urandom_range(0, 2) == 0);
      req       = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, 255));
      tick();
    end
    load = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_encoder_scan.md
Name: prio_encoder_scan

Overview:
- Parametrised, registered successor to the 4:2 encoder. Captures an N-bit request vector and emits the index of every set bit, one per handshake, in priority order.
- Order is highest index first by default, lowest first when selected.
- Sits between request/flag sources and a downstream consumer that services one request index at a time.

Parameters:
- N, 8, request vector width; must be >= 2.
- W, 3, index width; must satisfy 2**W >= N.
- HIGH_FIRST, 1, 1 = highest set index served first; 0 = lowest set index served first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load  input  1  capture req this cycle; honoured only when busy=0
- req  input  N  request vector; bit i means request for index i
- out_ready  input  1  consumer accepts out_idx this cycle
- out_valid  output  1  out_idx holds a pending request index
- out_idx  output  W  index of current highest-priority pending bit
- out_last  output  1  out_idx is the final pending bit of this batch
- busy  output  1  a batch is in progress; load ignored
- done  output  1  one-cycle pulse when a batch completes
- zero  output  1  one-cycle pulse: the accepted load had req == 0

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset state:
  - pending register = 0, FSM = IDLE.
  - out_valid = 0, out_idx = 0, out_last = 0, busy = 0, done = 0, zero = 0.
  - rst asserted mid-batch discards all pending bits immediately. No done pulse.
- FSM IDLE:
  - busy = 0, out_valid = 0, out_idx = 0.
  - load = 1 with req != 0: pending <= req, go to SCAN.
  - load = 1 with req == 0: stay IDLE. zero = 1 and done = 1 for exactly the next cycle.
  - load = 0: hold.
- FSM SCAN:
  - busy = 1, out_valid = 1.
  - out_idx = priority encode of pending: highest set bit if HIGH_FIRST = 1, else lowest set bit.
  - out_last = 1 when pending has exactly one bit set.
  - Transfer happens when out_valid & out_ready on a rising edge. On transfer the bit at out_idx is cleared in pending.
  - Transfer with out_last = 1: go to IDLE; done = 1 for the next cycle.
  - out_ready = 0: out_idx, out_last and pending hold stable (valid must not drop or change while stalled).
  - load during SCAN is ignored; req is not sampled.
- Timing:
  - Latency: load sampled at edge k gives out_valid = 1 and the first index after edge k.
  - Throughput: one index per cycle while out_ready = 1.
  - A batch with P set bits finishes in P cycles when out_ready is held at 1.
  - done is high in the cycle after the final transfer, with busy = 0 in the same cycle. A new load is accepted in that same cycle.
- Outputs are functions of registered state only; there is no combinational path from req, load or out_ready to any output.
- Priority encode must be a parametrised loop, not hard-wired gates. Index 0 is a legal index: it is distinguished from "no request" by out_valid, not by the index value.
- Bits of req at positions >= N do not exist. out_idx never exceeds N-1.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, before the next clk edge. FSM in IDLE.
- HIGH_FIRST=1, N=8, load req=8'b1010_0101, out_ready held 1:
  - out_idx sequence 7,5,2,0 on four consecutive cycles.
  - out_last = 1 only with idx 0.
  - done pulse on the cycle after; busy low on that cycle.
- HIGH_FIRST=0, same req:
  - sequence 0,2,5,7.
  - out_last with idx 7.
- Backpressure: req=8'b0001_1000, out_ready = 0 for 3 cycles, then 1:
  - out_idx holds 4 and out_valid holds 1 during the stall.
  - Then 4 followed by 3; done pulse once.
- Zero load and ignored load:
  - load req=0 -> zero and done pulse for one cycle; busy and out_valid stay 0.
  - load req=8'h81 during an active SCAN is ignored: the batch emits only its original bits.
- Reset mid-batch and back-to-back loads:
  - rst after first transfer of req=8'hF0 -> pending cleared, no done. A following load of 8'h01 emits only idx 0.
  - load asserted in the done cycle is accepted: the next batch starts the following cycle.
